// File: rtl/redirect_flush_ctrl.sv
// -----------------------------------------------------------------------------
// redirect_flush_ctrl
//
// Sequences front-end redirects and pipeline flushes after branch resolution
// or traps. One-cycle redirect events from EX (mispredict / late taken) and
// from the trap unit are turned into a valid/ready redirect to fetch. After
// fetch accepts, the IF/ID and ID/EX flushes stay asserted for a drain window.
// A saturating counter tracks accepted mispredicts.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   ex_redir_*        EX redirect event (pulse), target PC, mispredict flag
//   trap_valid/vector trap redirect event (pulse) and handler PC
//   trap_ack          registered pulse: trap taken or made pending
//   fe_redir_valid/pc redirect request to fetch, PC stable while valid
//   fe_redir_ready    fetch accepts redirect
//   flush_if_id/id_ex squash controls for the pipeline registers
//   busy              controller not idle
//   cnt_clr           synchronous clear of the mispredict counter
//   mispred_cnt       saturating mispredict count
// -----------------------------------------------------------------------------
module redirect_flush_ctrl #(
    parameter int DataWidth   = 32,
    parameter int DrainCycles = 2,
    parameter int CntWidth    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_redir_valid,
    input  logic [DataWidth-1:0] ex_redir_target,
    input  logic                 ex_redir_mispred,
    input  logic                 trap_valid,
    input  logic [DataWidth-1:0] trap_vector,
    output logic                 trap_ack,
    output logic                 fe_redir_valid,
    output logic [DataWidth-1:0] fe_redir_pc,
    input  logic                 fe_redir_ready,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 busy,
    input  logic                 cnt_clr,
    output logic [CntWidth-1:0]  mispred_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(DrainCycles);

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        return (&v) ? v : v + {{(CntWidth-1){1'b0}}, 1'b1};
    endfunction

    state_t               state;
    state_t               state_nxt;
    logic [3:0]           drain_cnt;
    logic [3:0]           drain_nxt;
    logic                 pend_valid;
    logic [DataWidth-1:0] pend_pc;

    logic                 trap_take;
    logic                 ex_take;
    logic                 pend_set;
    logic                 pend_clr;
    logic                 load_pc;
    logic [DataWidth-1:0] load_val;

    // Next-state and side-effect decode. Only fe_redir_ready influences the
    // transition out of REQ; all outputs are registered below.
    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        trap_take = 1'b0;
        ex_take   = 1'b0;
        pend_set  = 1'b0;
        pend_clr  = 1'b0;
        load_pc   = 1'b0;
        load_val  = fe_redir_pc;

        unique case (state)
            IDLE: begin
                if (pend_valid) begin
                    // Only reachable when a zero-length drain window let a
                    // trap land as pending; issue it right away.
                    state_nxt = REQ;
                    load_pc   = 1'b1;
                    load_val  = pend_pc;
                    pend_clr  = 1'b1;
                end else if (trap_valid) begin
                    // Trap wins; a same-cycle EX event is dropped.
                    trap_take = 1'b1;
                    state_nxt = REQ;
                    load_pc   = 1'b1;
                    load_val  = trap_vector;
                end else if (ex_redir_valid) begin
                    ex_take   = 1'b1;
                    state_nxt = REQ;
                    load_pc   = 1'b1;
                    load_val  = ex_redir_target;
                end
            end

            REQ: begin
                // EX events here are wrong-path and ignored.
                trap_take = trap_valid && !pend_valid;
                pend_set  = trap_take;
                if (fe_redir_ready) begin
                    if (DRAIN_INIT == 4'd0) begin
                        if (pend_valid) begin
                            state_nxt = REQ;
                            load_pc   = 1'b1;
                            load_val  = pend_pc;
                            pend_clr  = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        state_nxt = DRAIN;
                        drain_nxt = DRAIN_INIT;
                    end
                end
            end

            DRAIN: begin
                trap_take = trap_valid && !pend_valid;
                pend_set  = trap_take;
                if (drain_cnt <= 4'd1) begin
                    if (pend_valid) begin
                        state_nxt = REQ;
                        load_pc   = 1'b1;
                        load_val  = pend_pc;
                        pend_clr  = 1'b1;
                    end else if (trap_take) begin
                        // Trap in the final drain cycle feeds the REQ entry
                        // directly instead of parking in the pending slot.
                        pend_set  = 1'b0;
                        state_nxt = REQ;
                        load_pc   = 1'b1;
                        load_val  = trap_vector;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    drain_nxt = drain_cnt - 4'd1;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // State, registered outputs, pending trap slot and mispredict counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            drain_cnt      <= 4'd0;
            pend_valid     <= 1'b0;
            pend_pc        <= '0;
            fe_redir_pc    <= '0;
            fe_redir_valid <= 1'b0;
            flush_if_id    <= 1'b0;
            flush_id_ex    <= 1'b0;
            busy           <= 1'b0;
            trap_ack       <= 1'b0;
            mispred_cnt    <= '0;
        end else begin
            state          <= state_nxt;
            drain_cnt      <= drain_nxt;
            fe_redir_valid <= (state_nxt == REQ);
            flush_if_id    <= (state_nxt != IDLE);
            flush_id_ex    <= (state_nxt != IDLE);
            busy           <= (state_nxt != IDLE);
            trap_ack       <= trap_take;

            if (load_pc) begin
                fe_redir_pc <= load_val;
            end

            if (pend_set) begin
                pend_valid <= 1'b1;
                pend_pc    <= trap_vector;
            end else if (pend_clr) begin
                pend_valid <= 1'b0;
            end

            if (cnt_clr) begin
                mispred_cnt <= '0;
            end else if (ex_take && ex_redir_mispred) begin
                mispred_cnt <= sat_inc(mispred_cnt);
            end
        end
    end

endmodule

// File: tb/tb_redirect_flush_ctrl.sv
// -----------------------------------------------------------------------------
// tb_redirect_flush_ctrl
//
// Directed bench for redirect_flush_ctrl. Two instances share the inputs:
// u0 uses the default parameters, u1 has a 4-bit counter and no drain window.
// -----------------------------------------------------------------------------
module tb_redirect_flush_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_redir_valid = 1'b0;
    logic [31:0] ex_redir_target = '0;
    logic        ex_redir_mispred = 1'b0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_vector = '0;
    logic        fe_redir_ready = 1'b0;
    logic        cnt_clr = 1'b0;

    logic        u0_trap_ack, u0_valid, u0_flush_if_id, u0_flush_id_ex, u0_busy;
    logic [31:0] u0_pc;
    logic [15:0] u0_cnt;

    logic        u1_trap_ack, u1_valid, u1_flush_if_id, u1_flush_id_ex, u1_busy;
    logic [31:0] u1_pc;
    logic [3:0]  u1_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    redirect_flush_ctrl #(.DataWidth(32), .DrainCycles(2), .CntWidth(16)) u0 (
        .clk(clk), .rst_n(rst_n),
        .ex_redir_valid(ex_redir_valid), .ex_redir_target(ex_redir_target),
        .ex_redir_mispred(ex_redir_mispred),
        .trap_valid(trap_valid), .trap_vector(trap_vector), .trap_ack(u0_trap_ack),
        .fe_redir_valid(u0_valid), .fe_redir_pc(u0_pc), .fe_redir_ready(fe_redir_ready),
        .flush_if_id(u0_flush_if_id), .flush_id_ex(u0_flush_id_ex), .busy(u0_busy),
        .cnt_clr(cnt_clr), .mispred_cnt(u0_cnt)
    );

    redirect_flush_ctrl #(.DataWidth(32), .DrainCycles(0), .CntWidth(4)) u1 (
        .clk(clk), .rst_n(rst_n),
        .ex_redir_valid(ex_redir_valid), .ex_redir_target(ex_redir_target),
        .ex_redir_mispred(ex_redir_mispred),
        .trap_valid(trap_valid), .trap_vector(trap_vector), .trap_ack(u1_trap_ack),
        .fe_redir_valid(u1_valid), .fe_redir_pc(u1_pc), .fe_redir_ready(fe_redir_ready),
        .flush_if_id(u1_flush_if_id), .flush_id_ex(u1_flush_id_ex), .busy(u1_busy),
        .cnt_clr(cnt_clr), .mispred_cnt(u1_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_events();
        ex_redir_valid   = 1'b0;
        ex_redir_mispred = 1'b0;
        trap_valid       = 1'b0;
        cnt_clr          = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk1 ("rst_u0_valid", u0_valid, 1'b0);
        chk32("rst_u0_pc", u0_pc, 32'h0);
        chk1 ("rst_u0_flush_if_id", u0_flush_if_id, 1'b0);
        chk1 ("rst_u0_flush_id_ex", u0_flush_id_ex, 1'b0);
        chk1 ("rst_u0_busy", u0_busy, 1'b0);
        chk1 ("rst_u0_trap_ack", u0_trap_ack, 1'b0);
        chk32("rst_u0_cnt", 32'(u0_cnt), 32'h0);
        chk1 ("rst_u1_valid", u1_valid, 1'b0);
        chk32("rst_u1_pc", u1_pc, 32'h0);
        chk1 ("rst_u1_flush_if_id", u1_flush_if_id, 1'b0);
        chk1 ("rst_u1_flush_id_ex", u1_flush_id_ex, 1'b0);
        chk1 ("rst_u1_busy", u1_busy, 1'b0);
        chk1 ("rst_u1_trap_ack", u1_trap_ack, 1'b0);
        chk32("rst_u1_cnt", 32'(u1_cnt), 32'h0);
        rst_n = 1'b1;
        tick();

        // Test 1: EX mispredict, ready at REQ
        fe_redir_ready   = 1'b1;
        ex_redir_valid   = 1'b1;
        ex_redir_target  = 32'h0000_1000;
        ex_redir_mispred = 1'b1;
        tick();
        clear_events();
        chk1 ("t1_req_valid", u0_valid, 1'b1);
        chk32("t1_req_pc", u0_pc, 32'h0000_1000);
        chk1 ("t1_req_flush_if_id", u0_flush_if_id, 1'b1);
        chk1 ("t1_req_flush_id_ex", u0_flush_id_ex, 1'b1);
        chk1 ("t1_req_busy", u0_busy, 1'b1);
        chk32("t1_cnt", 32'(u0_cnt), 32'd1);
        tick();
        chk1 ("t1_d2_valid", u0_valid, 1'b0);
        chk1 ("t1_d2_flush", u0_flush_if_id, 1'b1);
        tick();
        chk1 ("t1_d1_flush", u0_flush_id_ex, 1'b1);
        tick();
        chk1 ("t1_idle_flush", u0_flush_if_id, 1'b0);
        chk1 ("t1_idle_busy", u0_busy, 1'b0);

        // Test 2: fetch stalls for 5 cycles, EX pulses ignored
        fe_redir_ready   = 1'b0;
        ex_redir_valid   = 1'b1;
        ex_redir_target  = 32'h0000_1000;
        ex_redir_mispred = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk1 ("t2_hold_valid", u0_valid, 1'b1);
            chk32("t2_hold_pc", u0_pc, 32'h0000_1000);
            chk32("t2_hold_cnt", 32'(u0_cnt), 32'd2);
            ex_redir_valid   = 1'b1;
            ex_redir_target  = 32'h0000_3000;
            ex_redir_mispred = 1'b1;
            tick();
        end
        clear_events();
        chk1 ("t2_end_valid", u0_valid, 1'b1);
        chk32("t2_end_pc", u0_pc, 32'h0000_1000);
        chk32("t2_end_cnt", 32'(u0_cnt), 32'd2);
        fe_redir_ready = 1'b1;
        tick();
        tick();
        tick();
        chk1 ("t2_idle_busy", u0_busy, 1'b0);

        // Test 3: trap and EX event in the same idle cycle
        fe_redir_ready   = 1'b0;
        trap_valid       = 1'b1;
        trap_vector      = 32'h8000_0000;
        ex_redir_valid   = 1'b1;
        ex_redir_target  = 32'h0000_2000;
        ex_redir_mispred = 1'b1;
        tick();
        clear_events();
        chk32("t3_pc", u0_pc, 32'h8000_0000);
        chk1 ("t3_trap_ack", u0_trap_ack, 1'b1);
        chk1 ("t3_valid", u0_valid, 1'b1);
        chk32("t3_cnt", 32'(u0_cnt), 32'd2);
        fe_redir_ready = 1'b1;
        tick();
        chk1 ("t3_ack_pulse", u0_trap_ack, 1'b0);
        chk1 ("t3_drain_valid", u0_valid, 1'b0);
        tick();
        tick();
        chk1 ("t3_idle_busy", u0_busy, 1'b0);

        // Test 4: trap during DRAIN, second trap while pending
        ex_redir_valid   = 1'b1;
        ex_redir_target  = 32'h0000_4000;
        ex_redir_mispred = 1'b0;
        tick();
        clear_events();
        chk32("t4_req_pc", u0_pc, 32'h0000_4000);
        tick();
        trap_valid  = 1'b1;
        trap_vector = 32'h9000_0000;
        tick();
        chk1 ("t4_pend_ack", u0_trap_ack, 1'b1);
        chk1 ("t4_drain_valid", u0_valid, 1'b0);
        chk1 ("t4_drain_flush", u0_flush_if_id, 1'b1);
        trap_valid  = 1'b1;
        trap_vector = 32'hA000_0000;
        tick();
        clear_events();
        chk1 ("t4_req_valid", u0_valid, 1'b1);
        chk32("t4_req_trap_pc", u0_pc, 32'h9000_0000);
        chk1 ("t4_second_no_ack", u0_trap_ack, 1'b0);
        chk1 ("t4_no_bubble", u0_busy, 1'b1);
        tick();
        chk1 ("t4_d2_valid", u0_valid, 1'b0);
        tick();
        tick();
        chk1 ("t4_idle_busy", u0_busy, 1'b0);
        chk1 ("t4_idle_valid", u0_valid, 1'b0);
        tick();
        chk1 ("t4_second_never", u0_valid, 1'b0);

        // Test 5: counter saturation and clear priority
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        fe_redir_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            ex_redir_valid   = 1'b1;
            ex_redir_target  = 32'h0000_0100;
            ex_redir_mispred = 1'b1;
            tick();
            clear_events();
            tick();
            tick();
            tick();
            tick();
        end
        chk32("t5_sat_u1", 32'(u1_cnt), 32'd15);
        chk32("t5_cnt_u0", 32'(u0_cnt), 32'd17);
        ex_redir_valid   = 1'b1;
        ex_redir_target  = 32'h0000_0200;
        ex_redir_mispred = 1'b1;
        cnt_clr          = 1'b1;
        tick();
        clear_events();
        chk32("t5_clr_u1", 32'(u1_cnt), 32'd0);
        chk32("t5_clr_u0", 32'(u0_cnt), 32'd0);
        chk1 ("t6_d0_req_valid", u1_valid, 1'b1);
        tick();
        chk1 ("t6_d0_idle_busy", u1_busy, 1'b0);
        chk1 ("t6_d0_idle_flush", u1_flush_if_id, 1'b0);
        chk1 ("t6_d0_u0_drain", u0_flush_if_id, 1'b1);
        tick();
        tick();

        // Test 6: asynchronous reset in REQ and in DRAIN
        fe_redir_ready   = 1'b0;
        ex_redir_valid   = 1'b1;
        ex_redir_target  = 32'h0000_5000;
        ex_redir_mispred = 1'b1;
        tick();
        clear_events();
        chk1 ("t6_req_valid", u0_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1 ("t6_req_rst_valid", u0_valid, 1'b0);
        chk32("t6_req_rst_pc", u0_pc, 32'h0);
        chk1 ("t6_req_rst_flush", u0_flush_id_ex, 1'b0);
        chk1 ("t6_req_rst_busy", u0_busy, 1'b0);
        chk32("t6_req_rst_cnt", 32'(u0_cnt), 32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        chk1 ("t6_req_after_busy", u0_busy, 1'b0);
        chk1 ("t6_req_after_valid", u0_valid, 1'b0);

        fe_redir_ready   = 1'b1;
        ex_redir_valid   = 1'b1;
        ex_redir_target  = 32'h0000_6000;
        ex_redir_mispred = 1'b0;
        tick();
        clear_events();
        tick();
        chk1 ("t6_drain_flush", u0_flush_if_id, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1 ("t6_drain_rst_flush", u0_flush_if_id, 1'b0);
        chk1 ("t6_drain_rst_busy", u0_busy, 1'b0);
        chk32("t6_drain_rst_pc", u0_pc, 32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        chk1 ("t6_drain_after_busy", u0_busy, 1'b0);
        tick();
        chk1 ("t6_drain_after_valid", u0_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
